// File: rtl/hack_cpu_sequencer.sv
// Multi-cycle Hack CPU control unit: fetches from the instruction ROM, drives the
// external ALU, owns A/D/PC and runs data-RAM reads/writes over a req/ack handshake.
module hack_cpu_sequencer #(
    parameter logic [14:0] RESET_PC    = 15'h0000,
    parameter int          ROM_LATENCY = 1
) (
    input  logic        clk_25,
    input  logic        reset,
    input  logic        run,
    output logic [14:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_ctl,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic        ram_req,
    output logic        ram_we,
    output logic [14:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    input  logic        ram_ack,
    output logic [14:0] pc_out,
    output logic [15:0] a_out,
    output logic [15:0] d_out,
    output logic        instr_done
);

    typedef enum logic [2:0] {
        FETCH,
        ROMWAIT,
        DECODE,
        MEMRD,
        EXEC,
        MEMWR
    } state_t;

    state_t      state;
    logic [14:0] pc;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic [15:0] m_reg;
    logic [12:0] ir;

    logic [14:0] pc_inc;
    logic        dest_a;
    logic        dest_d;
    logic        dest_m;
    logic        jump_taken;

    // ir keeps only bits 12:0; the opcode bits are consumed in DECODE and never needed again.
    assign pc_inc     = pc + 15'd1;
    assign dest_a     = ir[5];
    assign dest_d     = ir[4];
    assign dest_m     = ir[3];
    assign jump_taken = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr);

    assign rom_addr = pc;
    assign alu_x    = d_reg;
    assign alu_y    = ir[12] ? m_reg : a_reg;
    assign alu_ctl  = ir[11:6];
    assign pc_out   = pc;
    assign a_out    = a_reg;
    assign d_out    = d_reg;

    always_ff @(posedge clk_25) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            a_reg      <= 16'h0000;
            d_reg      <= 16'h0000;
            m_reg      <= 16'h0000;
            ir         <= 13'h0000;
            ram_req    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= 15'h0000;
            ram_wdata  <= 16'h0000;
            instr_done <= 1'b0;
        end else begin
            instr_done <= 1'b0;
            unique case (state)
                FETCH: begin
                    if (run) begin
                        state <= (ROM_LATENCY == 2) ? ROMWAIT : DECODE;
                    end
                end

                ROMWAIT: begin
                    state <= DECODE;
                end

                DECODE: begin
                    ir <= rom_data[12:0];
                    if (!rom_data[15]) begin
                        a_reg      <= {1'b0, rom_data[14:0]};
                        pc         <= pc_inc;
                        instr_done <= 1'b1;
                        state      <= FETCH;
                    end else if (rom_data[12]) begin
                        ram_req  <= 1'b1;
                        ram_we   <= 1'b0;
                        ram_addr <= a_reg[14:0];
                        state    <= MEMRD;
                    end else begin
                        state <= EXEC;
                    end
                end

                MEMRD: begin
                    if (ram_ack) begin
                        m_reg   <= ram_rdata;
                        ram_req <= 1'b0;
                        state   <= EXEC;
                    end
                end

                // Jump target and write address both use A as it was before this write.
                EXEC: begin
                    if (dest_a) begin
                        a_reg <= alu_out;
                    end
                    if (dest_d) begin
                        d_reg <= alu_out;
                    end
                    pc <= jump_taken ? a_reg[14:0] : pc_inc;
                    if (dest_m) begin
                        ram_req   <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_addr  <= a_reg[14:0];
                        ram_wdata <= alu_out;
                        state     <= MEMWR;
                    end else begin
                        instr_done <= 1'b1;
                        state      <= FETCH;
                    end
                end

                MEMWR: begin
                    if (ram_ack) begin
                        ram_req    <= 1'b0;
                        ram_we     <= 1'b0;
                        instr_done <= 1'b1;
                        state      <= FETCH;
                    end
                end

                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu_sequencer.sv
// Self-checking bench for hack_cpu_sequencer: ROM, ALU and RAM-arbiter models plus
// an instruction-level Hack reference model driving directed and random programs.
module tb_hack_cpu_sequencer;

    localparam logic [14:0] RESET_PC = 15'h0000;
    localparam int          ROM_LAT  = 1;

    logic        clk_25 = 1'b0;
    logic        reset;
    logic        run;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_ctl;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic        ram_req;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_ack;
    logic [14:0] pc_out;
    logic [15:0] a_out;
    logic [15:0] d_out;
    logic        instr_done;

    bit [15:0] rom [0:32767];
    bit [15:0] mem [0:32767];

    logic [15:0] mA;
    logic [15:0] mD;
    logic [14:0] mPC;

    int checks   = 0;
    int failures = 0;

    hack_cpu_sequencer #(
        .RESET_PC    (RESET_PC),
        .ROM_LATENCY (ROM_LAT)
    ) dut (
        .clk_25     (clk_25),
        .reset      (reset),
        .run        (run),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_ctl    (alu_ctl),
        .alu_out    (alu_out),
        .alu_zr     (alu_zr),
        .alu_ng     (alu_ng),
        .ram_req    (ram_req),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_ack    (ram_ack),
        .pc_out     (pc_out),
        .a_out      (a_out),
        .d_out      (d_out),
        .instr_done (instr_done)
    );

    always #20 clk_25 = ~clk_25;

    // Standard Hack ALU: zx, nx, zy, ny, f (add/and), no.
    function automatic logic [15:0] hackAlu(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] c);
        logic [15:0] xs;
        logic [15:0] ys;
        logic [15:0] o;
        xs = c[5] ? 16'h0000 : x;
        xs = c[4] ? ~xs : xs;
        ys = c[3] ? 16'h0000 : y;
        ys = c[2] ? ~ys : ys;
        o  = c[1] ? (xs + ys) : (xs & ys);
        return c[0] ? ~o : o;
    endfunction

    assign alu_out = hackAlu(alu_x, alu_y, alu_ctl);
    assign alu_zr  = (alu_out == 16'h0000);
    assign alu_ng  = alu_out[15];

    // Instruction ROM with one cycle of read latency.
    always @(posedge clk_25) rom_data <= rom[rom_addr];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkArch(input string tag);
        checkOutput({tag, "_pc"}, {17'd0, pc_out}, {17'd0, mPC});
        checkOutput({tag, "_a"}, {16'd0, a_out}, {16'd0, mA});
        checkOutput({tag, "_d"}, {16'd0, d_out}, {16'd0, mD});
    endtask

    // Executes one instruction from a held FETCH, acting as ROM and RAM arbiter,
    // and compares architectural results against the instruction-level model.
    task automatic applyStimulus(input logic [15:0] instr, input int ackDelay);
        logic [15:0] eA, eD, yv, res, wData;
        logic [14:0] ePC, wAddr, rAddr, holdAddr;
        logic [15:0] holdData;
        logic        holdWe, expRd, expWr, eJmp, readDone, inReq;
        int          expCycles, expReq, cycles, reqCycles, reqSeen, writes;

        rom[mPC] = instr;
        eA = mA; eD = mD; expRd = 1'b0; expWr = 1'b0;
        rAddr = mA[14:0]; wAddr = mA[14:0]; wData = 16'h0000;
        if (!instr[15]) begin
            eA = {1'b0, instr[14:0]};
            ePC = mPC + 15'd1;
            expCycles = 2;
        end else begin
            expRd = instr[12];
            yv    = expRd ? mem[mA[14:0]] : mA;
            res   = hackAlu(mD, yv, instr[11:6]);
            eJmp  = (instr[2] && res[15]) || (instr[1] && res == 16'h0000) ||
                    (instr[0] && !res[15] && res != 16'h0000);
            if (instr[5]) eA = res;
            if (instr[4]) eD = res;
            expWr = instr[3];
            wData = res;
            ePC   = eJmp ? mA[14:0] : mPC + 15'd1;
            expCycles = 3 + (expRd ? 1 + ackDelay : 0) + (expWr ? 1 + ackDelay : 0);
        end
        expCycles += ROM_LAT - 1;
        expReq = (expRd ? 1 + ackDelay : 0) + (expWr ? 1 + ackDelay : 0);

        run = 1'b1; cycles = 0; reqCycles = 0; reqSeen = 0; writes = 0;
        readDone = 1'b0; inReq = 1'b0;
        holdAddr = 15'h0; holdData = 16'h0; holdWe = 1'b0;
        while (1) begin
            if (ram_req) begin
                if (!inReq) begin
                    inReq = 1'b1; reqCycles = 0;
                    holdAddr = ram_addr; holdWe = ram_we; holdData = ram_wdata;
                    if (expRd && !readDone) begin
                        checkOutput("rd_we", {31'd0, ram_we}, 32'd0);
                        checkOutput("rd_addr", {17'd0, ram_addr}, {17'd0, rAddr});
                    end else begin
                        checkOutput("wr_we", {31'd0, ram_we}, 32'd1);
                        checkOutput("wr_addr", {17'd0, ram_addr}, {17'd0, wAddr});
                        checkOutput("wr_data", {16'd0, ram_wdata}, {16'd0, wData});
                    end
                end else begin
                    checkOutput("hold_addr", {17'd0, ram_addr}, {17'd0, holdAddr});
                    checkOutput("hold_we", {31'd0, ram_we}, {31'd0, holdWe});
                    if (holdWe) checkOutput("hold_wdata", {16'd0, ram_wdata}, {16'd0, holdData});
                end
                reqSeen++;
                ram_ack   = (reqCycles == ackDelay);
                ram_rdata = mem[ram_addr];
                if (ram_ack && !ram_we) readDone = 1'b1;
                if (ram_ack && ram_we) begin
                    mem[ram_addr] = ram_wdata;
                    writes++;
                end
                reqCycles++;
            end else begin
                inReq     = 1'b0;
                ram_ack   = ($urandom_range(0, 3) == 0);
                ram_rdata = 16'($urandom);
            end
            @(posedge clk_25);
            cycles++;
            @(negedge clk_25);
            if (cycles == 1) run = 1'b0;
            if (instr_done || cycles > 60) break;
        end
        ram_ack = 1'b0;

        checkOutput("done_seen", {31'd0, instr_done}, 32'd1);
        checkOutput("cycles", cycles, expCycles);
        checkOutput("req_cycles", reqSeen, expReq);
        checkOutput("writes", writes, expWr ? 1 : 0);
        mA = eA; mD = eD; mPC = ePC;
        checkArch("instr");
        checkOutput("rom_addr", {17'd0, rom_addr}, {17'd0, mPC});
    endtask

    // Holds with run low; nothing architectural may move.
    task automatic holdCycles(input int n);
        run = 1'b0;
        ram_ack = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_25);
            @(negedge clk_25);
            checkArch("hold");
            checkOutput("hold_done", {31'd0, instr_done}, 32'd0);
            checkOutput("hold_req", {31'd0, ram_req}, 32'd0);
            checkOutput("hold_romaddr", {17'd0, rom_addr}, {17'd0, mPC});
        end
    endtask

    initial begin
        logic [15:0] instr;
        int n;

        for (int i = 0; i < 32768; i++) begin
            rom[i] = 16'h0000;
            mem[i] = 16'($urandom);
        end
        reset = 1'b1; run = 1'b0; ram_ack = 1'b0; ram_rdata = 16'h0000;
        repeat (3) @(posedge clk_25);
        @(negedge clk_25);
        reset = 1'b0;
        mA = 16'h0000; mD = 16'h0000; mPC = RESET_PC;

        checkArch("reset");
        checkOutput("reset_req", {31'd0, ram_req}, 32'd0);
        checkOutput("reset_we", {31'd0, ram_we}, 32'd0);
        checkOutput("reset_raddr", {17'd0, ram_addr}, 32'd0);
        checkOutput("reset_wdata", {16'd0, ram_wdata}, 32'd0);
        checkOutput("reset_done", {31'd0, instr_done}, 32'd0);

        applyStimulus(16'h0008, 0);
        checkOutput("t1_a", {16'd0, a_out}, 32'h0008);
        checkOutput("t1_pc", {17'd0, pc_out}, 32'h0001);
        holdCycles(1);

        applyStimulus(16'hEC10, 0);
        applyStimulus(16'hE308, 3);
        checkOutput("t2_mem8", {16'd0, mem[8]}, 32'h0008);
        checkOutput("t2_pc", {17'd0, pc_out}, 32'h0003);

        mem[5] = 16'h0055;
        applyStimulus(16'h0005, 0);
        applyStimulus(16'hFC10, 0);
        checkOutput("t3_d", {16'd0, d_out}, 32'h0055);

        applyStimulus(16'h0014, 1);
        applyStimulus(16'hEA87, 0);
        checkOutput("t4_jmp_pc", {17'd0, pc_out}, 32'h0014);
        applyStimulus(16'h0001, 0);
        applyStimulus(16'hEC10, 0);
        applyStimulus(16'h0014, 0);
        applyStimulus(16'hE302, 0);

        applyStimulus(16'hEC20, 0);
        applyStimulus(16'hEDE7, 0);
        checkOutput("t5_oldA_pc", {17'd0, pc_out}, 32'h0014);
        checkOutput("t5_newA", {16'd0, a_out}, 32'h0015);
        applyStimulus(16'h7FFF, 0);
        applyStimulus(16'hEA87, 0);
        applyStimulus(16'h0000, 0);
        checkOutput("t5_wrap", {17'd0, pc_out}, 32'h0000);

        holdCycles(10);
        applyStimulus(16'h0003, 2);

        // Reset during a stalled MEMWR must drop ram_req at the very next edge.
        rom[mPC] = 16'hE308;
        run = 1'b1; ram_ack = 1'b0; n = 0;
        do begin
            @(posedge clk_25);
            @(negedge clk_25);
            run = 1'b0;
            n++;
        end while (!(ram_req && ram_we) && n < 20);
        checkOutput("t7_memwr", {31'd0, ram_req && ram_we}, 32'd1);
        repeat (2) begin
            @(posedge clk_25);
            @(negedge clk_25);
        end
        checkOutput("t7_stall_req", {31'd0, ram_req}, 32'd1);
        reset = 1'b1;
        @(posedge clk_25);
        @(negedge clk_25);
        reset = 1'b0;
        mA = 16'h0000; mD = 16'h0000; mPC = RESET_PC;
        checkOutput("t7_req_drop", {31'd0, ram_req}, 32'd0);
        checkOutput("t7_we_drop", {31'd0, ram_we}, 32'd0);
        checkArch("t7_reset");
        holdCycles(2);

        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 9) < 4) begin
                instr = {1'b0, 15'($urandom)};
            end else begin
                instr = {3'b111, 1'($urandom), 6'($urandom), 3'($urandom), 3'b000};
                if ($urandom_range(0, 1) == 1) instr[2:0] = 3'($urandom);
            end
            applyStimulus(instr, $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) holdCycles($urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hack_cpu_sequencer.md
Name: hack_cpu_sequencer

Overview:
- Multi-cycle control unit for the Hack CPU datapath.
- Fetches 16-bit Hack instructions from the instruction ROM and decodes them.
- Drives the external combinational ALUn2t (x, y, zx/nx/zy/ny/f/no) and consumes its out/zr/ng.
- Owns the A, D and PC registers. Sequences data-RAM reads and writes over a req/ack handshake, because RAM is shared with the VGA scan path.
- Sits between the instruction ROM, the ALUn2t instance and the RAM arbiter. Clocked from clk_25.

Parameters:
- RESET_PC, 15'h0000, PC value loaded on reset.
- ROM_LATENCY, 1, cycles from rom_addr to valid rom_data. Legal values: 1 or 2.

Ports:
- clk_25  in  1  system clock, 25 MHz from the clock divider
- reset  in  1  synchronous, active-high
- run  in  1  allow instruction fetch; low = hold before next fetch
- rom_addr  out  15  instruction address (equals PC)
- rom_data  in  16  instruction word, valid ROM_LATENCY cycles after rom_addr
- alu_x  out  16  ALU x operand (D)
- alu_y  out  16  ALU y operand (A or M)
- alu_ctl  out  6  {zx,nx,zy,ny,f,no}
- alu_out  in  16  ALU result
- alu_zr  in  1  ALU zero flag
- alu_ng  in  1  ALU negative flag
- ram_req  out  1  data-memory request
- ram_we  out  1  1 = write, 0 = read; valid while ram_req is high
- ram_addr  out  15  data address
- ram_wdata  out  16  write data
- ram_rdata  in  16  read data, valid in the ram_ack cycle
- ram_ack  in  1  transaction complete (1-cycle pulse)
- pc_out  out  15  current PC (debug)
- a_out  out  16  A register (debug)
- d_out  out  16  D register (debug)
- instr_done  out  1  1-cycle pulse when an instruction retires

Behaviour:
- Reset values: PC=RESET_PC, A=0, D=0, IR=0, M latch=0, state=FETCH, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, instr_done=0.
- A reset asserted mid-transaction drops ram_req on the very next edge; no ack is awaited.
- States: FETCH, ROMWAIT (present only if ROM_LATENCY=2), DECODE, MEMRD, EXEC, MEMWR.
- FETCH:
  - rom_addr=PC.
  - If run=0, stay in FETCH with no state change.
  - If run=1, go to ROMWAIT or DECODE.
  - run is sampled only in FETCH; an instruction in flight always completes.
- DECODE: IR<=rom_data.
  - If rom_data[15]=0 (A-instruction): A<={1'b0, rom_data[14:0]}, PC<=PC+1, instr_done=1, go to FETCH.
  - Else if rom_data[12]=1 (a-bit): go to MEMRD.
  - Else: go to EXEC.
- MEMRD: ram_req=1, ram_we=0, ram_addr=A[14:0]. Hold until ram_ack. On ack, M<=ram_rdata and go to EXEC. Ack in the first req cycle is legal.
- EXEC (ALU is combinational and settles within this cycle):
  - alu_x=D. alu_y = IR[12] ? M : A. alu_ctl=IR[11:6]. These are driven continuously from IR/A/D/M in all states.
  - Destinations IR[5:3]={d1,d2,d3}: d1 gives A<=alu_out, d2 gives D<=alu_out.
  - If d3=1: latch ram_addr<=old A[14:0] and ram_wdata<=alu_out.
  - Jump condition: jmp = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&~ng&~zr).
  - PC <= jmp ? old A[14:0] : PC+1. "Old A" means the value before this instruction's A write.
  - Next state: MEMWR if d3=1; otherwise FETCH with instr_done=1.
- MEMWR: ram_req=1, ram_we=1. ram_addr and ram_wdata are held stable until ram_ack. On ack: deassert next cycle, instr_done=1, go to FETCH.
- Handshake rule: ram_req stays high with constant addr/we/wdata until ack is sampled, then drops for at least one cycle (FETCH). ram_ack while ram_req=0 is ignored.
- Arithmetic: PC is 15-bit and wraps 7FFF to 0000. The A-instruction always clears A[15]. Addresses use A[14:0].
- Cycle counts at ROM_LATENCY=1, ack in the first cycle:
  - A-instruction: 2 cycles.
  - C-instruction without memory: 3 cycles.
  - C-instruction with M read: 4 cycles.
  - C-instruction with M write: 4 cycles.
  - C-instruction with M read and M write: 5 cycles.
  - ROM_LATENCY=2 adds 1 cycle to each. Each wait cycle before ack adds 1.

Test Plan:
- Reset, run=1, ROM[0]=16'h0008 (@8) -> after 2 cycles A=0008, PC=0001, instr_done pulses once; ram_req never asserts.
- ROM @8 then 16'hEC10 (D=A) then 16'hE308 (M=D) with A=8 -> D=0008; MEMWR asserts ram_we=1, ram_addr=0008, ram_wdata=0008; held through 3 ack-delay cycles; PC=0003.
- RAM[5]=16'h0055, ROM @5, 16'hFC10 (D=M) -> MEMRD request at addr 0005; after ack D=0055; total 4 cycles with immediate ack.
- ROM @20, 16'hEA87 (0;JMP) -> PC=0014 after EXEC. Then @20, 16'hE302 (D;JEQ) with D=1 -> PC=PC+1, not taken.
- 16'hEC20 (A=A) followed by a jump-form instruction -> the jump uses pre-write A. Also PC=7FFF executing @0 -> PC wraps to 0000.
- run=0 held in FETCH for 10 cycles -> PC, A, D unchanged and no ROM progress. Reset asserted during MEMWR wait -> ram_req=0 next cycle, PC=RESET_PC, A=D=0.
